// File: rtl/bcd_down_timer_if.sv
// bcd_down_timer_if: load/count controls and BCD readout of the countdown timer
interface bcd_down_timer_if #(parameter int DIGITS = 2);
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  en;
    logic [4*DIGITS-1:0]   q;
    logic                  busy;
    logic                  zero;
    logic                  tc;
    modport master (output load, load_val, en, input q, busy, zero, tc);
    modport slave  (input load, load_val, en, output q, busy, zero, tc);
endinterface

// File: rtl/bcd_down_timer.sv
// bcd_down_timer: loadable multi-digit BCD countdown timer with busy/zero/tc.
// Define BCD_AUTORELOAD_EN to restart from the last loaded value after each terminal count.
module bcd_down_timer #(
    parameter int DIGITS = 2
) (
    input logic            clk,
    input logic            reset,
    bcd_down_timer_if.slave bus
);
    localparam int W = 4*DIGITS;

    typedef enum logic {IDLE, RUN} state_t;

    state_t       state, state_n;
    logic [W-1:0] q, q_n, san, dec;
    logic         tc, tc_n, borrow;
`ifdef BCD_AUTORELOAD_EN
    logic [W-1:0] reload, reload_n;
`endif

    // Per-digit clamp of the preset and ripple-borrow decrement of q
    always_comb begin
        san = '0;
        dec = '0;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            san[4*i+:4] = bus.load_val[4*i+:4] > 4'd9 ? 4'd9 : bus.load_val[4*i+:4];
            dec[4*i+:4] = !borrow ? q[4*i+:4] : (q[4*i+:4] == 4'd0 ? 4'd9 : q[4*i+:4] - 4'd1);
            borrow = borrow && q[4*i+:4] == 4'd0;
        end
    end

    always_comb begin
        state_n = state;
        q_n = q;
        tc_n = 1'b0;
`ifdef BCD_AUTORELOAD_EN
        reload_n = reload;
`endif
        if (bus.load) begin
            q_n = san;
            state_n = san != '0 ? RUN : IDLE;
`ifdef BCD_AUTORELOAD_EN
            reload_n = san;
`endif
        end else if (state == RUN && bus.en) begin
`ifdef BCD_AUTORELOAD_EN
            // q==0 in RUN only happens after a terminal tick with a live reload value
            if (q == '0) begin
                q_n = reload;
            end else begin
                q_n = dec;
                tc_n = q == W'(1);
                state_n = (tc_n && reload == '0) ? IDLE : RUN;
            end
`else
            q_n = dec;
            tc_n = q == W'(1);
            state_n = tc_n ? IDLE : RUN;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            q <= '0;
            tc <= 1'b0;
`ifdef BCD_AUTORELOAD_EN
            reload <= '0;
`endif
        end else begin
            state <= state_n;
            q <= q_n;
            tc <= tc_n;
`ifdef BCD_AUTORELOAD_EN
            reload <= reload_n;
`endif
        end
    end

    assign bus.q    = q;
    assign bus.busy = state == RUN;
    assign bus.zero = q == '0;
    assign bus.tc   = tc;
endmodule

// File: tb/tb_bcd_down_timer.sv
// tb_bcd_down_timer: directed and random checks of two timer instances (2 and 3 digits)
// against a decimal-integer reference model.
module tb_bcd_down_timer;
`ifdef BCD_AUTORELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic        ld [2];
    logic [31:0] lv [2];
    logic        en [2];

    int tests = 0;
    int failed = 0;

    int unsigned m_n   [2];
    int unsigned m_rel [2];
    bit          m_run [2];
    bit          m_tc  [2];

    bcd_down_timer_if #(.DIGITS(2)) if0 ();
    bcd_down_timer_if #(.DIGITS(3)) if1 ();

    assign if0.load = ld[0];
    assign if0.load_val = lv[0][7:0];
    assign if0.en = en[0];
    assign if1.load = ld[1];
    assign if1.load_val = lv[1][11:0];
    assign if1.en = en[1];

    bcd_down_timer #(.DIGITS(2)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    bcd_down_timer #(.DIGITS(3)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned sanit(input logic [31:0] v, input int d);
        int unsigned r = 0, p = 1, dg;
        for (int i = 0; i < d; i++) begin
            dg = int'(v[4*i+:4]);
            if (dg > 9) dg = 9;
            r += dg * p;
            p *= 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] to_bcd(input int unsigned n, input int d);
        logic [31:0] r = '0;
        for (int i = 0; i < d; i++) begin
            r[4*i+:4] = 4'(n % 10);
            n /= 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_n[k] = 0; m_rel[k] = 0; m_run[k] = 0; m_tc[k] = 0;
        end
    endtask

    task automatic model_edge(input int k);
        m_tc[k] = 0;
        if (ld[k]) begin
            m_n[k] = sanit(lv[k], k == 0 ? 2 : 3);
            m_rel[k] = m_n[k];
            m_run[k] = m_n[k] != 0;
        end else if (m_run[k] && en[k]) begin
            if (m_n[k] == 0) m_n[k] = m_rel[k];
            else begin
                m_n[k]--;
                if (m_n[k] == 0) begin
                    m_tc[k] = 1;
                    if (!AR || m_rel[k] == 0) m_run[k] = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("q0", 32'(if0.q), to_bcd(m_n[0], 2));
        chk("busy0", 32'(if0.busy), 32'(m_run[0]));
        chk("zero0", 32'(if0.zero), 32'(m_n[0] == 0));
        chk("tc0", 32'(if0.tc), 32'(m_tc[0]));
        chk("q1", 32'(if1.q), to_bcd(m_n[1], 3));
        chk("busy1", 32'(if1.busy), 32'(m_run[1]));
        chk("zero1", 32'(if1.zero), 32'(m_n[1] == 0));
        chk("tc1", 32'(if1.tc), 32'(m_tc[1]));
    endtask

    task automatic cyc(input logic l0, input logic [31:0] v0, input logic e0,
                       input logic l1, input logic [31:0] v1, input logic e1);
        ld[0] = l0; lv[0] = v0; en[0] = e0;
        ld[1] = l1; lv[1] = v1; en[1] = e1;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        compare_all();
    endtask

    initial begin
        int ticks, tcc;
        logic [31:0] v;
        reset = 1'b1;
        ld[0] = 0; lv[0] = 0; en[0] = 0;
        ld[1] = 0; lv[1] = 0; en[1] = 0;
        model_reset();
        #1;
        compare_all();
        #2 reset = 1'b0;

        // Countdown 12 -> 00 then hold with en still high
        cyc(1, 32'h12, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) cyc(0, 0, 1, 0, 0, 0);
        chk("hold00", 32'(if0.q), 32'h00);

        // Sanitising and zero load
        cyc(1, 32'h3F, 1, 0, 0, 0);
        chk("sanit3F", 32'(if0.q), 32'h39);
        cyc(1, 32'h00, 1, 0, 0, 0);
        chk("load00_busy", 32'(if0.busy), 32'h0);

        // Enable gating, reload mid-count, load beating a terminal tick
        cyc(1, 32'h05, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("gate03", 32'(if0.q), 32'h03);
        cyc(1, 32'h20, 1, 0, 0, 0);
        for (int i = 0; i < 19; i++) cyc(0, 0, 1, 0, 0, 0);
        chk("at01", 32'(if0.q), 32'h01);
        cyc(1, 32'h20, 1, 0, 0, 0);
        chk("loadwins_tc", 32'(if0.tc), 32'h0);

        // Three-digit borrow chain and full-range countdown
        cyc(0, 0, 0, 1, 32'h100, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("borrow099", 32'(if1.q), 32'h099);
        cyc(0, 0, 0, 1, 32'h999, 0);
        ticks = 0;
        tcc = 0;
        do begin
            cyc(0, 0, 0, 0, 0, 1);
            ticks++;
            tcc += int'(if1.tc);
        end while (!if1.zero && ticks < 1100);
        chk("ticks999", 32'(ticks), 32'd999);
        chk("tc_count999", 32'(tcc), 32'd1);

        // Asynchronous reset while counting
        cyc(1, 32'h37, 0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        chk("rst_q37", 32'(if0.q), 32'h00);
        #1 reset = 1'b0;

        // Random traffic on both instances
        for (int i = 0; i < 3000; i++) begin
            logic l0, l1, e0, e1;
            logic [31:0] v1;
            l0 = $urandom_range(0, 15) == 0;
            l1 = $urandom_range(0, 31) == 0;
            e0 = $urandom_range(0, 3) != 0;
            e1 = $urandom_range(0, 3) != 0;
            v = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 9));
            v1 = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 25));
            cyc(l0, v, e0, l1, v1, e1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
